// File: rtl/gray_chk_pkg.sv
// Shared types, Gray constants and helpers for the Gray-step checker.
package gray_chk_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } chk_state_e;

    // Gray codes of decimal 9 and 0; the 9<->0 step is a legal three-bit jump.
    localparam logic [3:0] BCD_WRAP_HI = 4'b1101;
    localparam logic [3:0] BCD_WRAP_LO = 4'b0000;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [2:0] hamming4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x;
        x = a ^ b;
        return {2'b00, x[0]} + {2'b00, x[1]} + {2'b00, x[2]} + {2'b00, x[3]};
    endfunction

endpackage

// File: rtl/gray_step_checker_dec.sv
// Combinational Gray-to-BCD decode with out-of-range flag.
module gray2bcd_dec
    import gray_chk_pkg::*;
#(
    parameter int BCD_MAX = 9
) (
    input  logic [3:0] gray_in,
    output logic [3:0] bcd,
    output logic       over_max
);

    localparam logic [3:0] BCD_MAX_L = 4'(BCD_MAX);

    assign bcd      = gray2bin(gray_in);
    assign over_max = (bcd > BCD_MAX_L);

endmodule

// File: rtl/gray_step_checker.sv
// Checks that sampled Gray codes decode to BCD and move one legal step at a time.
// Optional direction output enabled by defining GRAY_STEP_DIR_EN.
module gray_step_checker
    import gray_chk_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int BCD_MAX = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       gray_in,
    input  logic             gray_vld,
    input  logic             cnt_clr,
    output logic [3:0]       bcd_out,
    output logic             bcd_vld,
    output logic             step_err,
    output logic             code_err,
    output logic [CNT_W-1:0] err_cnt
`ifdef GRAY_STEP_DIR_EN
    ,
    output logic [1:0]       dir
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    chk_state_e       state_r;
    chk_state_e       state_nxt_s;
    logic [3:0]       prev_r;
    logic [3:0]       prev_nxt_s;
    logic [3:0]       dec_s;
    logic             over_max_s;
    logic [2:0]       hd_s;
    logic             wrap_s;
    logic             step_ok_s;
    logic [3:0]       bcd_nxt_s;
    logic             bcd_vld_nxt_s;
    logic             step_err_nxt_s;
    logic             code_err_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
`ifdef GRAY_STEP_DIR_EN
    logic [3:0]       prev_bin_s;
    logic [3:0]       prev_inc_s;
    logic [3:0]       prev_dec_s;
    logic [1:0]       dir_nxt_s;
`endif

    gray2bcd_dec #(
        .BCD_MAX (BCD_MAX)
    ) u_dec (
        .gray_in  (gray_in),
        .bcd      (dec_s),
        .over_max (over_max_s)
    );

    assign hd_s      = hamming4(gray_in, prev_r);
    assign wrap_s    = ((gray_in == BCD_WRAP_LO) && (prev_r == BCD_WRAP_HI)) ||
                       ((gray_in == BCD_WRAP_HI) && (prev_r == BCD_WRAP_LO));
    assign step_ok_s = (hd_s <= 3'd1) || wrap_s;

`ifdef GRAY_STEP_DIR_EN
    assign prev_bin_s = gray2bin(prev_r);
    assign prev_inc_s = (prev_bin_s == 4'd9) ? 4'd0 : (prev_bin_s + 4'd1);
    assign prev_dec_s = (prev_bin_s == 4'd0) ? 4'd9 : (prev_bin_s - 4'd1);
`endif

    // Next-state, next-output and error-counter logic
    always_comb begin
        state_nxt_s    = state_r;
        prev_nxt_s     = prev_r;
        bcd_nxt_s      = bcd_out;
        bcd_vld_nxt_s  = 1'b0;
        step_err_nxt_s = 1'b0;
        code_err_nxt_s = 1'b0;
`ifdef GRAY_STEP_DIR_EN
        dir_nxt_s      = dir;
`endif
        if (gray_vld) begin
            if (over_max_s) begin
                // Out-of-range code drops the reference; next good sample resyncs.
                code_err_nxt_s = 1'b1;
                state_nxt_s    = IDLE;
            end else begin
                bcd_nxt_s     = dec_s;
                bcd_vld_nxt_s = 1'b1;
                prev_nxt_s    = gray_in;
                state_nxt_s   = TRACK;
                case (state_r)
                    IDLE: begin
                        step_err_nxt_s = 1'b0;
`ifdef GRAY_STEP_DIR_EN
                        dir_nxt_s      = 2'b00;
`endif
                    end
                    TRACK: begin
                        step_err_nxt_s = ~step_ok_s;
`ifdef GRAY_STEP_DIR_EN
                        if (!step_ok_s) begin
                            dir_nxt_s = 2'b00;
                        end else if (dec_s == prev_inc_s) begin
                            dir_nxt_s = 2'b01;
                        end else if (dec_s == prev_dec_s) begin
                            dir_nxt_s = 2'b10;
                        end else begin
                            dir_nxt_s = 2'b00;
                        end
`endif
                    end
                    default: begin
                        step_err_nxt_s = 1'b0;
                        state_nxt_s    = IDLE;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end

        if (cnt_clr) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if ((step_err_nxt_s || code_err_nxt_s) && (err_cnt != CNT_MAX)) begin
            cnt_nxt_s = err_cnt + CNT_ONE;
        end else begin
            cnt_nxt_s = err_cnt;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            prev_r   <= 4'b0000;
            bcd_out  <= 4'b0000;
            bcd_vld  <= 1'b0;
            step_err <= 1'b0;
            code_err <= 1'b0;
            err_cnt  <= {CNT_W{1'b0}};
`ifdef GRAY_STEP_DIR_EN
            dir      <= 2'b00;
`endif
        end else begin
            state_r  <= state_nxt_s;
            prev_r   <= prev_nxt_s;
            bcd_out  <= bcd_nxt_s;
            bcd_vld  <= bcd_vld_nxt_s;
            step_err <= step_err_nxt_s;
            code_err <= code_err_nxt_s;
            err_cnt  <= cnt_nxt_s;
`ifdef GRAY_STEP_DIR_EN
            dir      <= dir_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_gray_step_checker.sv
// Scoreboard bench for gray_step_checker; the model works from a digit-to-Gray table.
module tb_gray_step_checker;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic       gray_vld;
    logic       cnt_clr;
    logic [3:0] bcd_out;
    logic       bcd_vld;
    logic       step_err;
    logic       code_err;
    logic [7:0] err_cnt;
`ifdef GRAY_STEP_DIR_EN
    logic [1:0] dir;
`endif

    typedef struct {
        logic [3:0] bcd;
        logic       vld;
        logic       step;
        logic       code;
        logic [7:0] cnt;
        logic [1:0] dir;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [3:0] GRAY_TBL [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                             4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic       m_track;
    logic [3:0] m_prev;
    logic [3:0] m_bcd;
    logic [7:0] m_cnt;
    logic [1:0] m_dir;

    gray_step_checker #(
        .CNT_W   (8),
        .BCD_MAX (9)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .gray_vld (gray_vld),
        .cnt_clr  (cnt_clr),
        .bcd_out  (bcd_out),
        .bcd_vld  (bcd_vld),
        .step_err (step_err),
        .code_err (code_err),
        .err_cnt  (err_cnt)
`ifdef GRAY_STEP_DIR_EN
        ,
        .dir      (dir)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dig_of(input logic [3:0] g);
        for (int i = 0; i < 10; i++) begin
            if (GRAY_TBL[i] == g) return i;
        end
        return -1;
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [3:0] g, input logic c);
        exp_t e;
        exp_t o;
        int   idx;
        int   pd;
        int   d;
        logic wrap;
        @(negedge clk);
        rst      = r;
        gray_vld = v;
        gray_in  = g;
        cnt_clr  = c;
        e.vld  = 1'b0;
        e.step = 1'b0;
        e.code = 1'b0;
        if (r) begin
            m_track = 1'b0;
            m_prev  = 4'b0000;
            m_bcd   = 4'b0000;
            m_cnt   = 8'h00;
            m_dir   = 2'b00;
        end else begin
            if (v) begin
                idx = dig_of(g);
                if (idx < 0) begin
                    e.code  = 1'b1;
                    m_track = 1'b0;
                end else begin
                    if (m_track) begin
                        d    = $countones(g ^ m_prev);
                        wrap = (g == 4'b1101 && m_prev == 4'b0000) || (g == 4'b0000 && m_prev == 4'b1101);
                        e.step = !(d <= 1 || wrap);
                        pd = dig_of(m_prev);
                        if (e.step) m_dir = 2'b00;
                        else if (idx == (pd + 1) % 10) m_dir = 2'b01;
                        else if (idx == (pd + 9) % 10) m_dir = 2'b10;
                        else m_dir = 2'b00;
                    end else begin
                        m_dir = 2'b00;
                    end
                    m_bcd   = 4'(idx);
                    e.vld   = 1'b1;
                    m_prev  = g;
                    m_track = 1'b1;
                end
            end
            if (c) m_cnt = 8'h00;
            else if ((e.step || e.code) && m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
        end
        e.bcd = m_bcd;
        e.cnt = m_cnt;
        e.dir = m_dir;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check("bcd_vld",  32'(bcd_vld),  32'(o.vld));
        check("bcd_out",  32'(bcd_out),  32'(o.bcd));
        check("step_err", 32'(step_err), 32'(o.step));
        check("code_err", 32'(code_err), 32'(o.code));
        check("err_cnt",  32'(err_cnt),  32'(o.cnt));
`ifdef GRAY_STEP_DIR_EN
        check("dir",      32'(dir),      32'(o.dir));
`endif
    endtask

    task automatic dig(input int n);
        cycle(1'b0, 1'b1, GRAY_TBL[n], 1'b0);
    endtask

    initial begin
        rst = 1'b1; gray_vld = 1'b0; gray_in = 4'b0000; cnt_clr = 1'b0;
        m_track = 1'b0; m_prev = 4'b0000; m_bcd = 4'b0000; m_cnt = 8'h00; m_dir = 2'b00;

        cycle(1'b1, 1'b0, 4'b0000, 1'b0);
        cycle(1'b1, 1'b1, 4'b0111, 1'b1);

        // first digits, then full ascent with upward and downward wrap
        for (int i = 0; i < 4; i++) dig(i);
        for (int i = 0; i < 10; i++) dig(i);
        dig(0);
        dig(9);
        dig(8);
        dig(8);

        // step error from 0 to 5, then legal 5 -> 6
        dig(0);
        cycle(1'b0, 1'b1, 4'b0111, 1'b0);
        cycle(1'b0, 1'b1, 4'b0101, 1'b0);

        // code error in TRACK, gap, then resync without step check
        cycle(1'b0, 1'b1, 4'b1111, 1'b0);
        cycle(1'b0, 1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 1'b1, 4'b1101, 1'b0);
        cycle(1'b0, 1'b1, 4'b1110, 1'b0);
        cycle(1'b0, 1'b1, 4'b1000, 1'b0);

        // saturate the counter, then clear it together with an error
        dig(0);
        for (int i = 0; i < 259; i++) cycle(1'b0, 1'b1, (i % 2 == 0) ? 4'b0111 : 4'b0000, 1'b0);
        cycle(1'b0, 1'b1, 4'b1111, 1'b1);
        cycle(1'b0, 1'b1, 4'b0111, 1'b0);

        // reach err_cnt=5 in TRACK, reset, then first sample is not step-checked
        cycle(1'b0, 1'b0, 4'b0000, 1'b1);
        dig(0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, (i % 2 == 0) ? 4'b0111 : 4'b0000, 1'b0);
        cycle(1'b1, 1'b1, 4'b0111, 1'b0);
        cycle(1'b0, 1'b1, 4'b0111, 1'b0);
        cycle(1'b0, 1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 1'b0, 4'b1111, 1'b0);
        dig(6);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
